instruction_cache: RTL and testbench
====================================

// Module: instruction_cache
// PURPOSE
//   Direct-mapped, read-only instruction cache sitting between the CPU fetch port and instruction memory.
//   Serves PC-addressed 32-bit instructions to the CPU and stalls it via INS_CACHE_BUSY_WAIT on a miss.
//   Refills one 128-bit block from instruction memory through a level read/busywait handshake.
// PARAMETERS
//   NUM_LINES        8    cache lines (power of 2); index width IDX_W = log2(NUM_LINES)
//   WORDS_PER_BLOCK  4    32-bit words per line; block = 128 bits
//   ADDR_BITS        10   PC bits used; PC[31:ADDR_BITS] ignored; PC[1:0] ignored (word aligned)
// PORTS
//   CLK                  in   1    clock, all state on posedge
//   RESET                in   1    synchronous, active-high
//   PC                   in   32   fetch address from CPU
//   insReadEn            in   1    CPU fetch request, high for one cycle after each PC update
//   INSTRUCTION          out  32   fetched instruction; valid when INS_CACHE_BUSY_WAIT low
//   INS_CACHE_BUSY_WAIT  out  1    stall to CPU; high while a miss is outstanding
//   mem_read             out  1    read request to instruction memory
//   mem_address          out  6    block address = PC[ADDR_BITS-1:4]
//   mem_readdata         in   128  block from memory; word0 in [31:0]
//   mem_busywait         in   1    memory busy; low with mem_read high = data valid
// BEHAVIOUR
//   Address split (defaults): tag=PC[9:7], index=PC[6:4], word offset=PC[3:2].
//   Per line: valid bit, tag (ADDR_BITS-4-IDX_W bits), 128-bit data.
//   Reset: all valid bits 0, state IDLE, mem_read 0, mem_address 0, INS_CACHE_BUSY_WAIT 0, INSTRUCTION 0.
//   FSM states IDLE, MEM_READ, UPDATE:
//   IDLE: hit = valid[index] && tag match. Combinational: INSTRUCTION = data[index][offset].
//     insReadEn && hit  -> busy 0, stay IDLE (zero extra cycles).
//     insReadEn && !hit -> busy 1 same cycle; capture tag/index; next MEM_READ.
//     insReadEn low     -> no lookup, busy 0, stay IDLE.
//   MEM_READ: mem_read 1, mem_address = captured {tag,index}, busy 1; both held stable.
//     mem_busywait ignored in first MEM_READ cycle.
//     Thereafter, posedge with mem_busywait 0 -> latch mem_readdata, go UPDATE.
//   UPDATE (1 cycle): mem_read 0, busy 1; write data, tag, valid=1 into captured index; next IDLE.
//     Lookup in that IDLE cycle hits; busy drops; CPU advances PC on following edge.
//   Miss latency: 1 (detect) + memory wait + 1 (UPDATE) + 1 (hit) cycles.
//   Boundaries:
//     Refill overwrites a valid conflicting line unconditionally; no write path.
//     PC -4 (0xFFFFFFFC) during CPU reset: insReadEn is 0, no lookup, no refill.
//     RESET mid-miss: drop mem_read same edge, abandon refill, invalidate all lines, IDLE.
//     Late memory data after that is ignored.
//     insReadEn re-asserted while busy: ignored; cache serves captured miss only.
//     PC is held by the CPU while busy.
//     Line with valid=0: INSTRUCTION is don't-care; busy governs.
// STRUCTURE
//   Shared package icache_pkg: state encoding (IDLE/MEM_READ/UPDATE) and default field widths.
//   Widths: TAG_W, IDX_W, OFF_W; block width 128.
//   Sub-module icache_array: valid/tag/data storage.
//     Async read by index; sync write on UPDATE; sync clear on RESET.
//   Top: hit compare, word mux, FSM, memory interface registers.
// TESTING
//   Cold miss: reset, PC=0, insReadEn -> busy 1, mem_read 1, mem_address 0; mem returns
//     128'h..._00000003_00000002_00000001_00000000 after 5 busy cycles -> UPDATE.
//     Next cycle INSTRUCTION=0x00000000, busy 0.
//   Sequential hits: PC=4,8,12 after refill -> INSTRUCTION 1,2,3, busy never high, mem_read stays 0.
//   Conflict eviction: PC=0x000 then 0x080 (same index 0, tag 1) -> second refill, mem_address 8.
//     Then PC=0x000 misses again.
//   Index spread: PC=0x010..0x070 each miss once; repeat pass -> all hits, zero mem_read cycles.
//   Reset mid-refill: RESET during MEM_READ -> mem_read 0 next edge, busy 0.
//     Re-fetch of same PC misses (valid cleared).
//   Slow/fast memory: mem_busywait low on 2nd MEM_READ cycle vs held 20 cycles.
//     Correct data both; mem_address stable throughout.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared widths and FSM state encoding for the direct-mapped instruction cache.
package icache_pkg;

  localparam int unsigned NUM_LINES       = 8;
  localparam int unsigned WORDS_PER_BLOCK = 4;
  localparam int unsigned ADDR_BITS       = 10;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned BLOCK_W    = WORD_W * WORDS_PER_BLOCK;
  localparam int unsigned OFF_W      = $clog2(WORDS_PER_BLOCK);
  localparam int unsigned IDX_W      = $clog2(NUM_LINES);
  localparam int unsigned BLK_ADDR_W = ADDR_BITS - 2 - OFF_W;
  localparam int unsigned TAG_W      = BLK_ADDR_W - IDX_W;

  typedef enum logic [1:0] {
    IDLE,
    MEM_READ,
    UPDATE
  } state_t;

endpackage

// File: rtl/instruction_cache_array.sv
// Valid/tag/data storage: asynchronous read by index, synchronous line write and clear.
module icache_array
  import icache_pkg::*;
(
  input  logic               CLK,
  input  logic               RESET,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_data,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_idx,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_data
);

  logic               valid_q [NUM_LINES];
  logic [TAG_W-1:0]   tag_q   [NUM_LINES];
  logic [BLOCK_W-1:0] data_q  [NUM_LINES];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      // Data is cleared too so INSTRUCTION reads as zero straight out of reset.
      for (int unsigned i = 0; i < NUM_LINES; i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        data_q[i]  <= '0;
      end
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      tag_q[wr_idx]   <= wr_tag;
      data_q[wr_idx]  <= wr_data;
    end
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache: hit compare, word select, refill FSM
// and the level read/busywait interface to instruction memory.
module instruction_cache
  import icache_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic [31:0]           PC,
  input  logic                  insReadEn,
  output logic [31:0]           INSTRUCTION,
  output logic                  INS_CACHE_BUSY_WAIT,
  output logic                  mem_read,
  output logic [BLK_ADDR_W-1:0] mem_address,
  input  logic [BLOCK_W-1:0]    mem_readdata,
  input  logic                  mem_busywait
);

  state_t state, next_state;

  logic [IDX_W-1:0]      pc_idx;
  logic [TAG_W-1:0]      pc_tag;
  logic [OFF_W-1:0]      pc_off;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [BLOCK_W-1:0]    rd_data;
  logic [WORDS_PER_BLOCK-1:0][WORD_W-1:0] rd_words;
  logic                  hit;
  logic                  miss_req;
  logic                  wr_en;
  logic [BLK_ADDR_W-1:0] cap_addr;
  logic [BLOCK_W-1:0]    fill_data;
  logic                  first_rd;
  logic                  unused_pc_bits;

  assign pc_off = PC[2 +: OFF_W];
  assign pc_idx = PC[2 + OFF_W +: IDX_W];
  assign pc_tag = PC[2 + OFF_W + IDX_W +: TAG_W];
  assign unused_pc_bits = ^{PC[31:ADDR_BITS], PC[1:0]};

  icache_array u_array (
    .CLK      (CLK),
    .RESET    (RESET),
    .rd_idx   (pc_idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .wr_en    (wr_en),
    .wr_idx   (cap_addr[IDX_W-1:0]),
    .wr_tag   (cap_addr[BLK_ADDR_W-1 -: TAG_W]),
    .wr_data  (fill_data)
  );

  assign rd_words    = rd_data;
  assign INSTRUCTION = rd_words[pc_off];
  assign hit         = rd_valid && (rd_tag == pc_tag);
  assign miss_req    = (state == IDLE) && insReadEn && !hit;
  assign mem_address = cap_addr;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      cap_addr  <= '0;
      fill_data <= '0;
      first_rd  <= 1'b0;
    end else begin
      state <= next_state;
      if (miss_req) begin
        cap_addr <= PC[ADDR_BITS-1 -: BLK_ADDR_W];
        first_rd <= 1'b1;
      end
      // The first MEM_READ cycle only launches the request; busywait is not trusted yet.
      if (state == MEM_READ) begin
        first_rd <= 1'b0;
        if (!first_rd && !mem_busywait) fill_data <= mem_readdata;
      end
    end
  end

  always_comb begin
    next_state          = state;
    INS_CACHE_BUSY_WAIT = 1'b0;
    mem_read            = 1'b0;
    wr_en               = 1'b0;
    case (state)
      IDLE: begin
        if (miss_req) begin
          INS_CACHE_BUSY_WAIT = 1'b1;
          next_state          = MEM_READ;
        end
      end
      MEM_READ: begin
        INS_CACHE_BUSY_WAIT = 1'b1;
        mem_read            = 1'b1;
        if (!first_rd && !mem_busywait) next_state = UPDATE;
      end
      UPDATE: begin
        INS_CACHE_BUSY_WAIT = 1'b1;
        wr_en               = 1'b1;
        next_state          = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instruction_cache.sv
// Directed self-checking bench for instruction_cache with a bench-driven memory model.
module tb_instruction_cache;

  logic         CLK = 1'b0;
  logic         RESET = 1'b1;
  logic [31:0]  PC = '0;
  logic         insReadEn = 1'b0;
  logic [31:0]  INSTRUCTION;
  logic         INS_CACHE_BUSY_WAIT;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata = '0;
  logic         mem_busywait = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  instruction_cache dut (
    .CLK                 (CLK),
    .RESET               (RESET),
    .PC                  (PC),
    .insReadEn           (insReadEn),
    .INSTRUCTION         (INSTRUCTION),
    .INS_CACHE_BUSY_WAIT (INS_CACHE_BUSY_WAIT),
    .mem_read            (mem_read),
    .mem_address         (mem_address),
    .mem_readdata        (mem_readdata),
    .mem_busywait        (mem_busywait)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Memory content: word w of block address a holds {a, w}, i.e. PC[9:2] of that word.
  function automatic logic [127:0] blk(input logic [31:0] pc);
    logic [5:0] a;
    a = pc[9:4];
    return {24'd0, a, 2'd3, 24'd0, a, 2'd2, 24'd0, a, 2'd1, 24'd0, a, 2'd0};
  endfunction

  task automatic fetch(input logic [31:0] pc, input bit exp_miss,
                       input int unsigned wait_cyc, input string tag);
    logic [31:0]  exp_ins;
    logic [5:0]   exp_addr;
    int unsigned  cyc;
    int unsigned  exp_cyc;
    exp_ins  = {22'd0, pc[9:2]};
    exp_addr = pc[9:4];
    exp_cyc  = ((wait_cyc > 1) ? wait_cyc : 1) + 1;
    @(posedge CLK); #1;
    PC = pc; insReadEn = 1'b1; mem_busywait = 1'b1;
    #1;
    chk({tag, ".busy"}, INS_CACHE_BUSY_WAIT, exp_miss);
    if (!exp_miss) begin
      chk({tag, ".ins"}, INSTRUCTION, exp_ins);
      chk({tag, ".mrd"}, mem_read, 1'b0);
    end else begin
      cyc = 0;
      @(posedge CLK); #1;
      chk({tag, ".mrd_on"}, mem_read, 1'b1);
      while (mem_read && cyc < 100) begin
        chk({tag, ".addr"}, mem_address, exp_addr);
        mem_busywait = (cyc < wait_cyc);
        mem_readdata = mem_busywait ? {4{32'hDEADBEEF}} : blk(pc);
        @(posedge CLK); #1;
        cyc++;
      end
      mem_busywait = 1'b1;
      mem_readdata = {4{32'hBAADF00D}};
      chk({tag, ".rdcyc"}, cyc, exp_cyc);
      chk({tag, ".upd_busy"}, INS_CACHE_BUSY_WAIT, 1'b1);
      @(posedge CLK); #1;
      chk({tag, ".hit_busy"}, INS_CACHE_BUSY_WAIT, 1'b0);
      chk({tag, ".ins"}, INSTRUCTION, exp_ins);
      chk({tag, ".mrd_off"}, mem_read, 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    chk("rst.busy", INS_CACHE_BUSY_WAIT, 1'b0);
    chk("rst.mrd", mem_read, 1'b0);
    chk("rst.addr", mem_address, 6'd0);
    chk("rst.ins", INSTRUCTION, 32'd0);
    RESET = 1'b0;

    // CPU still in reset: PC = -4 without insReadEn triggers nothing
    PC = 32'hFFFF_FFFC; insReadEn = 1'b0;
    #1;
    chk("pcm4.busy", INS_CACHE_BUSY_WAIT, 1'b0);
    repeat (2) begin
      @(posedge CLK); #1;
      chk("pcm4.mrd", mem_read, 1'b0);
      chk("pcm4.busy2", INS_CACHE_BUSY_WAIT, 1'b0);
    end

    // Cold miss, then sequential hits in the same block
    fetch(32'h000, 1'b1, 5, "cold");
    fetch(32'h004, 1'b0, 0, "seq4");
    fetch(32'h008, 1'b0, 0, "seq8");
    fetch(32'h00C, 1'b0, 0, "seq12");

    // Conflict eviction on index 0 with fast memory, then slow memory refetch
    fetch(32'h080, 1'b1, 1, "evict");
    fetch(32'h084, 1'b0, 0, "evict_hit");
    fetch(32'h000, 1'b1, 20, "reload_slow");
    fetch(32'h008, 1'b0, 0, "reload_hit");

    // Index spread: one miss per index, then all hits (upper PC bits ignored)
    for (int i = 1; i < 8; i++) fetch(32'(i) << 4, 1'b1, 2, "spread_miss");
    for (int i = 0; i < 8; i++)
      fetch(32'hABCD_0000 | (32'(i) << 4) | 32'h4, 1'b0, 0, "spread_hit");

    // Reset in the middle of a refill
    @(posedge CLK); #1;
    PC = 32'h100; insReadEn = 1'b1; mem_busywait = 1'b1;
    #1;
    chk("midrst.busy", INS_CACHE_BUSY_WAIT, 1'b1);
    @(posedge CLK); #1;
    chk("midrst.mrd", mem_read, 1'b1);
    chk("midrst.addr", mem_address, 6'h10);
    @(posedge CLK); #1;
    RESET = 1'b1; insReadEn = 1'b0;
    @(posedge CLK); #1;
    chk("midrst.mrd_drop", mem_read, 1'b0);
    chk("midrst.busy_drop", INS_CACHE_BUSY_WAIT, 1'b0);
    RESET = 1'b0;
    mem_busywait = 1'b0; mem_readdata = blk(32'h100);
    repeat (2) begin
      @(posedge CLK); #1;
      chk("late.mrd", mem_read, 1'b0);
      chk("late.busy", INS_CACHE_BUSY_WAIT, 1'b0);
    end
    mem_busywait = 1'b1;

    // Lines were invalidated by the reset
    fetch(32'h000, 1'b1, 3, "post_rst");
    fetch(32'h070, 1'b1, 0, "post_rst7");
    fetch(32'h00C, 1'b0, 0, "post_rst_hit");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
